// File: rtl/awgn_pkg.sv
// Shared Q-format widths, reset gain and serial-output state encoding for the AWGN output stage.
package awgn_pkg;

  localparam int G_W     = 16;  // sin/cos, signed Q1.15
  localparam int F_W     = 17;  // sqrt, unsigned Q4.13
  localparam int GAIN_W  = 16;  // sigma gain, unsigned Q2.14
  localparam int P1_W    = 33;  // g*f, signed Q5.28
  localparam int P2_W    = 49;  // g*f*gain, signed Q7.42
  localparam int P2_FRAC = 42;

  localparam logic [GAIN_W-1:0] GAIN_ONE = 16'h4000;

  typedef enum logic [0:0] {
    SEND_X0 = 1'b0,
    SEND_X1 = 1'b1
  } serial_state_t;

  function automatic logic signed [P1_W-1:0] stage1_mul(input logic signed [G_W-1:0] g,
                                                        input logic        [F_W-1:0] f);
    return P1_W'(g * $signed({1'b0, f}));
  endfunction

  function automatic logic signed [P2_W-1:0] stage2_mul(input logic signed [P1_W-1:0] p,
                                                        input logic      [GAIN_W-1:0] gain);
    return P2_W'(p * $signed({1'b0, gain}));
  endfunction

endpackage

// File: rtl/awgn_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the head entry, valid whenever count is non-zero.
module awgn_sync_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
  assign push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);

  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/awgn_output_stage.sv
// Scales Box-Muller sin/cos/sqrt pairs by a programmable sigma, rounds and saturates to OUT_W,
// and buffers the result behind a credit-based input so the pipeline never stalls.
module awgn_output_stage
  import awgn_pkg::*;
#(
  parameter int OUT_W      = 16,
  parameter int OUT_FRAC   = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int SERIAL     = 0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [G_W-1:0]                              g0_in,
  input  logic [G_W-1:0]                              g1_in,
  input  logic [F_W-1:0]                              f_in,
  input  logic                                        gain_wr,
  input  logic [GAIN_W-1:0]                           gain_in,
  input  logic                                        clr_stats,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [(SERIAL != 0 ? OUT_W : 2*OUT_W)-1:0]  out_data,
  output logic                                        out_last,
  output logic [15:0]                                 sat_count
);

  localparam int SH     = P2_FRAC - OUT_FRAC;
  localparam int PAIR_W = 2 * OUT_W;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic signed [P2_W:0] ONE_Q  = {{P2_W{1'b0}}, 1'b1};
  localparam logic signed [P2_W:0] HALF_Q = ONE_Q <<< (SH - 1);
  localparam logic signed [P2_W:0] MAX_Q  = (ONE_Q <<< (OUT_W - 1)) - ONE_Q;
  localparam logic signed [P2_W:0] MIN_Q  = -(ONE_Q <<< (OUT_W - 1));

  // Returns {saturated, sample}: round half-up at the OUT_FRAC boundary, then clamp.
  function automatic logic [OUT_W:0] round_sat(input logic signed [P2_W-1:0] p);
    logic signed [P2_W:0] r;
    logic signed [P2_W:0] q;
    r = $signed({p[P2_W-1], p}) + HALF_Q;
    q = r >>> SH;
    if (q > MAX_Q) begin
      round_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end else if (q < MIN_Q) begin
      round_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      round_sat = {1'b0, q[OUT_W-1:0]};
    end
  endfunction

  logic                     run_r;
  logic [GAIN_W-1:0]        gain_r;
  logic                     v1_r, v2_r, v3_r;
  logic signed [P1_W-1:0]   p1a_r, p1b_r;
  logic [GAIN_W-1:0]        gain1_r;
  logic signed [P2_W-1:0]   p2a_r, p2b_r;
  logic [OUT_W-1:0]         x0_r, x1_r;
  logic [15:0]              sat_count_r;
  serial_state_t            state_r, state_nxt_s;

  logic                     accept_s;
  logic [CW:0]              occ_s;
  logic [OUT_W:0]           rs0_s, rs1_s;
  logic [16:0]              sat_sum_s;
  logic                     hs_s;
  logic                     pop_s;
  logic [PAIR_W-1:0]        fifo_rdata_s;
  logic [CW-1:0]            fifo_count_s;

  // A pop this cycle is deliberately not credited: occupancy uses the registered count only.
  assign occ_s    = {1'b0, fifo_count_s} + {{CW{1'b0}}, v1_r} + {{CW{1'b0}}, v2_r} + {{CW{1'b0}}, v3_r};
  assign in_ready = run_r && (occ_s < (CW+1)'(FIFO_DEPTH));
  assign accept_s = in_valid && in_ready;

  assign rs0_s     = round_sat(p2a_r);
  assign rs1_s     = round_sat(p2b_r);
  assign sat_sum_s = {1'b0, sat_count_r} + {16'd0, rs0_s[OUT_W]} + {16'd0, rs1_s[OUT_W]};

  assign out_valid = (fifo_count_s != {CW{1'b0}});
  assign hs_s      = out_valid && out_ready;
  assign pop_s     = hs_s && ((SERIAL == 0) || (state_r == SEND_X1));
  assign sat_count = sat_count_r;

  // gain register and post-reset input enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_r  <= 1'b0;
      gain_r <= GAIN_ONE;
    end else begin
      run_r <= 1'b1;
      if (gain_wr) begin
        gain_r <= gain_in;
      end
    end
  end

  // three-stage arithmetic pipeline; the gain sampled at acceptance rides with the pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      v3_r    <= 1'b0;
      p1a_r   <= {P1_W{1'b0}};
      p1b_r   <= {P1_W{1'b0}};
      gain1_r <= {GAIN_W{1'b0}};
      p2a_r   <= {P2_W{1'b0}};
      p2b_r   <= {P2_W{1'b0}};
      x0_r    <= {OUT_W{1'b0}};
      x1_r    <= {OUT_W{1'b0}};
    end else begin
      v1_r <= accept_s;
      v2_r <= v1_r;
      v3_r <= v2_r;
      if (accept_s) begin
        p1a_r   <= stage1_mul($signed(g0_in), f_in);
        p1b_r   <= stage1_mul($signed(g1_in), f_in);
        gain1_r <= gain_r;
      end
      if (v1_r) begin
        p2a_r <= stage2_mul(p1a_r, gain1_r);
        p2b_r <= stage2_mul(p1b_r, gain1_r);
      end
      if (v2_r) begin
        x0_r <= rs0_s[OUT_W-1:0];
        x1_r <= rs1_s[OUT_W-1:0];
      end
    end
  end

  // saturation statistics, sticky at all-ones, clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_count_r <= 16'd0;
    end else if (clr_stats) begin
      sat_count_r <= 16'd0;
    end else if (v2_r) begin
      sat_count_r <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
    end else begin
      sat_count_r <= sat_count_r;
    end
  end

  awgn_sync_fifo #(
    .W     (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (v3_r),
    .wdata ({x1_r, x0_r}),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s)
  );

  // serial FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= SEND_X0;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // serial FSM next state; parallel mode stays in SEND_X0
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SEND_X0: begin
        if ((SERIAL != 0) && hs_s) begin
          state_nxt_s = SEND_X1;
        end else begin
          state_nxt_s = SEND_X0;
        end
      end
      SEND_X1: begin
        if (hs_s) begin
          state_nxt_s = SEND_X0;
        end else begin
          state_nxt_s = SEND_X1;
        end
      end
      default: state_nxt_s = SEND_X0;
    endcase
  end

  if (SERIAL != 0) begin : g_serial
    // beat select: x0 first, then x1 flagged last
    always_comb begin
      out_data = {OUT_W{1'b0}};
      out_last = 1'b0;
      if (out_valid && (state_r == SEND_X1)) begin
        out_data = fifo_rdata_s[PAIR_W-1:OUT_W];
        out_last = 1'b1;
      end else if (out_valid) begin
        out_data = fifo_rdata_s[OUT_W-1:0];
        out_last = 1'b0;
      end else begin
        out_data = {OUT_W{1'b0}};
        out_last = 1'b0;
      end
    end
  end else begin : g_parallel
    // whole pair per beat
    always_comb begin
      out_data = {PAIR_W{1'b0}};
      out_last = run_r;
      if (out_valid) begin
        out_data = fifo_rdata_s;
      end else begin
        out_data = {PAIR_W{1'b0}};
      end
    end
  end

endmodule
